decode_stage: RTL and testbench

Parametrised RV32I/RV32E decode pipeline stage with integrated register file and write-back bypass. It accepts an instruction and PC over a valid/ready handshake and decodes every base immediate format (R/I/S/B/U/J). It reads both source operands and holds the result in a single-entry output register toward execute. Write-back from later stages enters through a dedicated port and is forwarded, both into incoming reads and into a stalled held entry.

---
 rtl/decode_stage.sv | 147 ++++++++++++++
 tb/tb_decode_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: immediate/format decode, register file read with
// write-back bypass, and a single-entry output register toward execute.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int AW = $clog2(NREG);
  localparam logic [5:0] NREGV = 6'(NREG);

  logic [XLEN-1:0]    regs [NREG];
  logic               capture;
  logic               wbWrite;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [4:0]         rd;
  logic [2:0]         fmt;
  logic signed [31:0] imm32;
  logic               useRs1;
  logic               useRs2;
  logic               useRd;
  logic               idxIll;
  logic [XLEN-1:0]    src1;
  logic [XLEN-1:0]    src2;

  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready;
  assign wbWrite  = wb_en & (wb_addr != 5'd0) & ({1'b0, wb_addr} < NREGV);

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];

  always_comb begin
    fmt    = 3'd7;
    imm32  = '0;
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    useRd  = 1'b0;
    if (in_inst[1:0] == 2'b11) begin
      case (in_inst[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b11100: begin
          fmt    = 3'd1;
          imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
          useRs1 = 1'b1;
          useRd  = 1'b1;
        end
        5'b01000: begin
          fmt    = 3'd2;
          imm32  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
          useRs1 = 1'b1;
          useRs2 = 1'b1;
        end
        5'b11000: begin
          fmt    = 3'd3;
          imm32  = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
          useRs1 = 1'b1;
          useRs2 = 1'b1;
        end
        5'b01101, 5'b00101: begin
          fmt   = 3'd4;
          imm32 = {in_inst[31:12], 12'b0};
          useRd = 1'b1;
        end
        5'b11011: begin
          fmt   = 3'd5;
          imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
          useRd = 1'b1;
        end
        5'b01100: begin
          fmt    = 3'd0;
          useRs1 = 1'b1;
          useRs2 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Only fields the format actually uses can make an RV32E encoding illegal.
  assign idxIll = (useRs1 & ({1'b0, rs1} >= NREGV)) |
                  (useRs2 & ({1'b0, rs2} >= NREGV)) |
                  (useRd  & ({1'b0, rd}  >= NREGV));

  assign src1 = (rs1 == 5'd0) ? '0 :
                (wbWrite && wb_addr == rs1) ? wb_data : regs[rs1[AW-1:0]];
  assign src2 = (rs2 == 5'd0) ? '0 :
                (wbWrite && wb_addr == rs2) ? wb_data : regs[rs2[AW-1:0]];

  // A held entry keeps tracking write-back so execute never sees a stale operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_fmt     <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (wbWrite) regs[wb_addr[AW-1:0]] <= wb_data;
      if (capture) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_src1    <= src1;
        out_src2    <= src2;
        out_rs1     <= rs1;
        out_rs2     <= rs2;
        out_rd      <= rd;
        out_imm     <= XLEN'(imm32);
        out_fmt     <= fmt;
        out_illegal <= (fmt == 3'd7) | idxIll;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else if (out_valid) begin
        if (wbWrite && wb_addr == out_rs1) out_src1 <= wb_data;
        if (wbWrite && wb_addr == out_rs2) out_src2 <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage; an RV32I and an RV32E instance
// share stimulus and are compared against a behavioural model.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_ready;

  logic        inReady [2];
  logic        outValid [2];
  logic [31:0] outPc [2];
  logic [31:0] outSrc1 [2];
  logic [31:0] outSrc2 [2];
  logic [4:0]  outRs1 [2];
  logic [4:0]  outRs2 [2];
  logic [4:0]  outRd [2];
  logic [31:0] outImm [2];
  logic [2:0]  outFmt [2];
  logic        outIll [2];

  logic [31:0] mRegs [2][32];
  logic        mValid [2];
  logic [31:0] mPc [2];
  logic [31:0] mSrc1 [2];
  logic [31:0] mSrc2 [2];
  logic [4:0]  mRs1 [2];
  logic [4:0]  mRs2 [2];
  logic [4:0]  mRd [2];
  logic [31:0] mImm [2];
  logic [2:0]  mFmt [2];
  logic        mIll [2];

  int checkCount = 0;
  int passCount  = 0;

  decode_stage #(.XLEN(32), .NREG(32)) dutI (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[0]),
    .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(outValid[0]), .out_ready(out_ready),
    .out_pc(outPc[0]), .out_src1(outSrc1[0]), .out_src2(outSrc2[0]),
    .out_rs1(outRs1[0]), .out_rs2(outRs2[0]), .out_rd(outRd[0]),
    .out_imm(outImm[0]), .out_fmt(outFmt[0]), .out_illegal(outIll[0])
  );

  decode_stage #(.XLEN(32), .NREG(16)) dutE (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[1]),
    .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(outValid[1]), .out_ready(out_ready),
    .out_pc(outPc[1]), .out_src1(outSrc1[1]), .out_src2(outSrc2[1]),
    .out_rs1(outRs1[1]), .out_rs2(outRs2[1]), .out_rd(outRd[1]),
    .out_imm(outImm[1]), .out_fmt(outFmt[1]), .out_illegal(outIll[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Immediates are rebuilt as weighted sums of instruction fields.
  function automatic void decodeRef(input logic [31:0] inst, input int nreg,
                                    output logic [2:0] fmt, output logic [31:0] imm,
                                    output logic ill);
    int s;
    bit u1, u2, ud;
    s = $signed(inst);
    fmt = 3'd7; imm = 0; u1 = 0; u2 = 0; ud = 0;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b11100: begin
          fmt = 1; imm = s >>> 20; u1 = 1; ud = 1;
        end
        5'b01000: begin
          fmt = 2; imm = (s >>> 25) * 32 + int'(inst[11:7]); u1 = 1; u2 = 1;
        end
        5'b11000: begin
          fmt = 3;
          imm = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
          u1 = 1; u2 = 1;
        end
        5'b01101, 5'b00101: begin
          fmt = 4; imm = inst & 32'hFFFFF000; ud = 1;
        end
        5'b11011: begin
          fmt = 5;
          imm = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
          ud = 1;
        end
        5'b01100: begin
          fmt = 0; u1 = 1; u2 = 1;
        end
        default: ;
      endcase
    end
    ill = (fmt == 7) || (u1 && int'(inst[19:15]) >= nreg) ||
          (u2 && int'(inst[24:20]) >= nreg) || (ud && int'(inst[11:7]) >= nreg);
  endfunction

  function automatic logic [31:0] regRead(input int k, input logic [4:0] r, input bit wbw);
    if (r == 0) return 0;
    if (wbw && wb_addr == r) return wb_data;
    return mRegs[k][r];
  endfunction

  task automatic modelStep(input int k, input int nreg);
    logic [2:0] f;
    logic [31:0] im;
    logic il;
    bit cap, wbw;
    cap = in_valid && (!mValid[k] || out_ready);
    wbw = wb_en && wb_addr != 0 && int'(wb_addr) < nreg;
    if (rst) begin
      for (int i = 0; i < 32; i++) mRegs[k][i] = 0;
      mValid[k] = 0; mPc[k] = 0; mSrc1[k] = 0; mSrc2[k] = 0;
      mRs1[k] = 0; mRs2[k] = 0; mRd[k] = 0; mImm[k] = 0; mFmt[k] = 0; mIll[k] = 0;
    end else begin
      if (cap) begin
        decodeRef(in_inst, nreg, f, im, il);
        mValid[k] = 1; mPc[k] = in_pc;
        mRs1[k] = in_inst[19:15]; mRs2[k] = in_inst[24:20]; mRd[k] = in_inst[11:7];
        mSrc1[k] = regRead(k, in_inst[19:15], wbw);
        mSrc2[k] = regRead(k, in_inst[24:20], wbw);
        mImm[k] = im; mFmt[k] = f; mIll[k] = il;
      end else if (mValid[k] && out_ready) begin
        mValid[k] = 0;
      end else if (mValid[k]) begin
        if (wbw && wb_addr == mRs1[k]) mSrc1[k] = wb_data;
        if (wbw && wb_addr == mRs2[k]) mSrc2[k] = wb_data;
      end
      if (wbw) mRegs[k][wb_addr] = wb_data;
    end
  endtask

  // Operands named by an index beyond the RV32E file are left unchecked.
  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("in_ready%0d", k), 64'(inReady[k]), 64'(!mValid[k] || out_ready));
      checkOutput($sformatf("out_valid%0d", k), 64'(outValid[k]), 64'(mValid[k]));
      checkOutput($sformatf("out_pc%0d", k), 64'(outPc[k]), 64'(mPc[k]));
      checkOutput($sformatf("out_rs1_%0d", k), 64'(outRs1[k]), 64'(mRs1[k]));
      checkOutput($sformatf("out_rs2_%0d", k), 64'(outRs2[k]), 64'(mRs2[k]));
      checkOutput($sformatf("out_rd%0d", k), 64'(outRd[k]), 64'(mRd[k]));
      checkOutput($sformatf("out_imm%0d", k), 64'(outImm[k]), 64'(mImm[k]));
      checkOutput($sformatf("out_fmt%0d", k), 64'(outFmt[k]), 64'(mFmt[k]));
      checkOutput($sformatf("out_illegal%0d", k), 64'(outIll[k]), 64'(mIll[k]));
      if (!(k == 1 && mRs1[k] >= 16))
        checkOutput($sformatf("out_src1_%0d", k), 64'(outSrc1[k]), 64'(mSrc1[k]));
      if (!(k == 1 && mRs2[k] >= 16))
        checkOutput($sformatf("out_src2_%0d", k), 64'(outSrc2[k]), 64'(mSrc2[k]));
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] inst,
                               input logic [31:0] pc, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = iv; in_inst = inst; in_pc = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    modelStep(0, 32);
    modelStep(1, 16);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  logic [4:0] opTable [12];

  initial begin
    logic [31:0] inst;
    opTable = '{5'b00000, 5'b00100, 5'b11001, 5'b11100, 5'b01000, 5'b11000,
                5'b01101, 5'b00101, 5'b11011, 5'b01100, 5'b00011, 5'b10100};
    rst = 1; in_valid = 0; in_inst = 0; in_pc = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 32'h00500093, 32'h40, 1, 5, 32'h1234, 1);
    checkOutput("reset_valid", 64'(outValid[0]), 64'd0);
    checkOutput("reset_imm", 64'(outImm[0]), 64'd0);

    applyStimulus(0, 0, 0, 0, 1, 1, 32'h5, 1);
    applyStimulus(0, 1, 32'h00500093, 32'h100, 0, 0, 0, 1);
    checkOutput("addi_valid", 64'(outValid[0]), 64'd1);
    checkOutput("addi_fmt", 64'(outFmt[0]), 64'd1);
    checkOutput("addi_imm", 64'(outImm[0]), 64'h5);
    checkOutput("addi_rd", 64'(outRd[0]), 64'd1);
    checkOutput("addi_src1", 64'(outSrc1[0]), 64'd0);

    applyStimulus(0, 1, 32'hFE000EE3, 32'h104, 0, 0, 0, 1);
    checkOutput("beq_fmt", 64'(outFmt[0]), 64'd3);
    checkOutput("beq_imm", 64'(outImm[0]), 64'hFFFFFFFC);
    applyStimulus(0, 1, 32'h123451B7, 32'h108, 0, 0, 0, 1);
    checkOutput("lui_fmt", 64'(outFmt[0]), 64'd4);
    checkOutput("lui_imm", 64'(outImm[0]), 64'h12345000);
    checkOutput("lui_rd", 64'(outRd[0]), 64'd3);

    applyStimulus(0, 1, 32'h00528333, 32'h10C, 1, 5, 32'hDEADBEEF, 1);
    checkOutput("add_bypass1", 64'(outSrc1[0]), 64'hDEADBEEF);
    checkOutput("add_bypass2", 64'(outSrc2[0]), 64'hDEADBEEF);
    applyStimulus(0, 1, 32'h123451B7, 32'h110, 1, 5, 32'h11111111, 0);
    checkOutput("hold_src1", 64'(outSrc1[0]), 64'h11111111);
    checkOutput("hold_src2", 64'(outSrc2[0]), 64'h11111111);
    checkOutput("hold_ready", 64'(inReady[0]), 64'd0);
    checkOutput("hold_rd", 64'(outRd[0]), 64'd6);
    applyStimulus(0, 1, 32'h123451B7, 32'h110, 0, 0, 0, 1);
    checkOutput("release_fmt", 64'(outFmt[0]), 64'd4);
    checkOutput("release_pc", 64'(outPc[0]), 64'h110);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1);
    applyStimulus(0, 1, 32'h00000333, 32'h114, 0, 0, 0, 1);
    checkOutput("x0_src1", 64'(outSrc1[0]), 64'd0);
    applyStimulus(0, 1, 32'h0000007F, 32'h118, 0, 0, 0, 1);
    checkOutput("bad_fmt", 64'(outFmt[0]), 64'd7);
    checkOutput("bad_ill", 64'(outIll[0]), 64'd1);
    applyStimulus(0, 1, 32'h01000893, 32'h11C, 0, 0, 0, 1);
    checkOutput("rv32e_ill", 64'(outIll[1]), 64'd1);
    checkOutput("rv32e_fmt", 64'(outFmt[1]), 64'd1);
    checkOutput("rv32i_ok", 64'(outIll[0]), 64'd0);

    applyStimulus(0, 1, 32'h00528333, 32'h120, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("prerst_src", 64'(outSrc1[1]), 64'h11111111);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_hold", 64'(outValid[1]), 64'd0);
    applyStimulus(0, 1, 32'h00528333, 32'h124, 0, 0, 0, 1);
    checkOutput("rst_x5", 64'(outSrc1[1]), 64'd0);

    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      if ($urandom_range(0, 7) != 0) inst[6:0] = {opTable[$urandom_range(0, 11)], 2'b11};
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, inst, $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
